alu_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single 32-bit ALU/compare datapath between two requesters (e.g. the execute stage and the branch-compare unit). It accepts one operation at a time over a valid/ready handshake and drives the shared ALU's busA/busB/op inputs. It captures dataOut plus the zero/overflow/carryout/negative flags and returns them to the winning requester as a one-cycle response pulse.

---
 rtl/alu_arbiter.sv | 81 ++++++++
 tb/tb_alu_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one registered ALU datapath
// Ports: clk/reset (sync, active-high); req{0,1}_valid/ready/a/b/op request side;
// alu_busA/busB/op registered ALU inputs; alu_dataOut + 4 flags combinational ALU outputs;
// rsp{0,1}_valid one-cycle response pulse; rsp_data/rsp_flags {zero,overflow,carryout,negative}.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic [OPW-1:0]   req1_op,
   output logic [WIDTH-1:0] alu_busA,
   output logic [WIDTH-1:0] alu_busB,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_dataOut,
   input  logic             alu_zeroFlag,
   input  logic             alu_overflowFlag,
   input  logic             alu_carryoutFlag,
   input  logic             alu_negativeFlag,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp_data,
   output logic [3:0]       rsp_flags
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   logic [1:0]       state_q, state_d;
   logic             prio_q, owner_q;
   logic [WIDTH-1:0] busa_q, busb_q, data_q;
   logic [OPW-1:0]   op_q;
   logic [3:0]       flags_q;
   logic             grant, win;
   assign grant = state_q == IDLE && (req0_valid || req1_valid);
   // win is the granted id: prio breaks a tie, otherwise the lone valid wins
   assign win = (req0_valid && req1_valid) ? prio_q : req1_valid;
   assign req0_ready = !reset && grant && !win;
   assign req1_ready = !reset && grant && win;
   assign rsp0_valid = state_q == RESP && !owner_q;
   assign rsp1_valid = state_q == RESP && owner_q;
   assign alu_busA = busa_q;
   assign alu_busB = busb_q;
   assign alu_op = op_q;
   assign rsp_data = data_q;
   assign rsp_flags = flags_q;
   always_comb state_d = state_q == IDLE ? (grant ? EXEC : IDLE) : state_q == EXEC ? RESP : IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         busa_q  <= '0;
         busb_q  <= '0;
         op_q    <= '0;
         data_q  <= '0;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         if (grant) begin
            busa_q  <= win ? req1_a : req0_a;
            busb_q  <= win ? req1_b : req0_b;
            op_q    <= win ? req1_op : req0_op;
            owner_q <= win;
            prio_q  <= !win;
         end
         if (state_q == EXEC) begin
            data_q  <= alu_dataOut;
            flags_q <= {alu_zeroFlag, alu_overflowFlag, alu_carryoutFlag, alu_negativeFlag};
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a small ALU model
module tb_alu_arbiter;
   logic        clk = 0, reset = 1;
   logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [31:0] req0_a = 0, req1_a = 0, req0_b = 0, req1_b = 0;
   logic [2:0]  req0_op = 0, req1_op = 0;
   logic [31:0] alu_busA, alu_busB, alu_dataOut, rsp_data;
   logic [2:0]  alu_op;
   logic        zf, vf, cf, nf, rsp0_valid, rsp1_valid;
   logic [3:0]  rsp_flags;
   logic [32:0] sum;
   int          total = 0, bad = 0;
   always #5 clk = ~clk;
   // ALU model: op0 add, op1 sub, op7 signed slt, else xor; carry/overflow only for add
   always_comb begin
      sum = {1'b0, alu_busA} + {1'b0, alu_busB};
      alu_dataOut = alu_op == 3'd7 ? {31'd0, $signed(alu_busA) < $signed(alu_busB)} :
                    alu_op == 3'd0 ? sum[31:0] : alu_op == 3'd1 ? alu_busA - alu_busB : alu_busA ^ alu_busB;
      cf = alu_op == 3'd0 && sum[32];
      vf = alu_op == 3'd0 && alu_busA[31] == alu_busB[31] && sum[31] != alu_busA[31];
      zf = alu_dataOut == 32'd0;
      nf = alu_dataOut[31];
   end
   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op),
      .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_op(alu_op),
      .alu_dataOut(alu_dataOut), .alu_zeroFlag(zf), .alu_overflowFlag(vf),
      .alu_carryoutFlag(cf), .alu_negativeFlag(nf),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic rsp_chk(input string tag, input logic r0, input logic r1, input logic [31:0] d, input logic [3:0] f);
      chk({tag, "_rsp0"}, rsp0_valid, r0);
      chk({tag, "_rsp1"}, rsp1_valid, r1);
      chk({tag, "_data"}, rsp_data, d);
      chk({tag, "_flags"}, rsp_flags, f);
   endtask
   initial begin
      req0_valid = 1;
      req1_valid = 1;
      tick();
      #1;
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_busA", alu_busA, 0);
      chk("rst_busB", alu_busB, 0);
      chk("rst_op", alu_op, 0);
      rsp_chk("rst", 0, 0, 0, 4'b0000);
      req0_valid = 0;
      req1_valid = 0;
      reset = 0;
      tick();
      req0_valid = 1; req0_a = 5; req0_b = 9; req0_op = 3'b111;
      #1;
      chk("single_rdy0", req0_ready, 1);
      chk("single_rdy1", req1_ready, 0);
      tick();
      req0_valid = 0;
      #1;
      chk("single_busA", alu_busA, 5);
      chk("single_busB", alu_busB, 9);
      chk("single_op", alu_op, 7);
      chk("single_exec_rdy", req0_ready, 0);
      tick();
      rsp_chk("single", 1, 0, 1, 4'b0000);
      tick();
      chk("single_idle_rsp0", rsp0_valid, 0);
      reset = 1;
      tick();
      reset = 0;
      req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 3'd0;
      req1_valid = 1; req1_a = 10; req1_b = 3; req1_op = 3'd1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("alt%0d_rdy0", k), req0_ready, k % 2 == 0);
         chk($sformatf("alt%0d_rdy1", k), req1_ready, k % 2 == 1);
         tick();
         chk($sformatf("alt%0d_exec_rdy", k), {req0_ready, req1_ready}, 2'b00);
         tick();
         rsp_chk($sformatf("alt%0d", k), k % 2 == 0, k % 2 == 1, k % 2 ? 32'd7 : 32'd3, 4'b0000);
         tick();
      end
      req0_valid = 0;
      req1_valid = 0;
      tick();
      req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 1; req0_op = 3'd0;
      tick();
      req0_valid = 0;
      tick();
      rsp_chk("flag", 1, 0, 0, 4'b1010);
      for (int k = 0; k < 3; k++) begin
         tick();
         rsp_chk($sformatf("flag_hold%0d", k), 0, 0, 0, 4'b1010);
      end
      req0_valid = 1; req0_a = 6; req0_b = 3; req0_op = 3'd0;
      tick();
      req0_valid = 0;
      req1_valid = 1; req1_a = 4; req1_b = 4; req1_op = 3'd1;
      #1;
      chk("late_exec_rdy1", req1_ready, 0);
      tick();
      chk("late_resp_rdy1", req1_ready, 0);
      rsp_chk("late_r0", 1, 0, 9, 4'b0000);
      tick();
      chk("late_idle_rdy1", req1_ready, 1);
      tick();
      req1_valid = 0;
      tick();
      rsp_chk("late_r1", 0, 1, 0, 4'b1000);
      tick();
      req0_valid = 1; req0_a = 7; req0_b = 7; req0_op = 3'd0;
      tick();
      req0_valid = 0;
      reset = 1;
      tick();
      reset = 0;
      chk("midrst_busA", alu_busA, 0);
      chk("midrst_busB", alu_busB, 0);
      chk("midrst_op", alu_op, 0);
      rsp_chk("midrst", 0, 0, 0, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("midrst_nopulse%0d", k), {rsp0_valid, rsp1_valid}, 2'b00);
      end
      req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 3'd0;
      req1_valid = 1; req1_a = 10; req1_b = 3; req1_op = 3'd1;
      #1;
      chk("midrst_prio_rdy0", req0_ready, 1);
      chk("midrst_prio_rdy1", req1_ready, 0);
      tick();
      req0_valid = 0;
      req1_valid = 0;
      tick();
      rsp_chk("midrst_op", 1, 0, 3, 4'b0000);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("idle%0d", k), {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0000);
      end
      chk("idle_busA", alu_busA, 1);
      chk("idle_busB", alu_busB, 2);
      chk("idle_op", alu_op, 0);
      chk("idle_data", rsp_data, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
